// File: rtl/bwt_occ_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bwt_occ_pkg                                                          |
// | Shared types and constants for the BWT occurrence-line responder.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`ifndef READ_NUM_WIDTH
`define READ_NUM_WIDTH 8
`endif

package bwt_occ_pkg;

  // Occurrence-line address and memory line geometry.
  localparam int ADDR_W  = 42;
  localparam int LINE_W  = 512;
  localparam int FIELD_W = 384;  // bits [383:0] carry counters, the rest is padding
  localparam int CNT_A_W = 32;
  localparam int CNT_B_W = 64;

  // Bit offsets of each counter inside a memory line.
  localparam int A0_LSB = 0;
  localparam int A1_LSB = 32;
  localparam int A2_LSB = 64;
  localparam int A3_LSB = 96;
  localparam int B0_LSB = 128;
  localparam int B1_LSB = 192;
  localparam int B2_LSB = 256;
  localparam int B3_LSB = 320;

  // Lookup sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_K = 3'd1,
    ST_ISSUE_L = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESP    = 3'd4
  } occ_state_t;

endpackage
`default_nettype wire

// File: rtl/occ_req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | occ_req_fifo                                                         |
// | Synchronous request FIFO holding {tag, addr_k, addr_l} entries.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module occ_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Fullness comes from the registered count only, so a pop in the same
  // cycle never frees a slot for a push.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bwt_occ_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bwt_occ_responder                                                    |
// | Fetches the k and l occurrence lines for each queued lookup and      |
// | returns their counter fields, one lookup in flight, in order.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module bwt_occ_responder
  import bwt_occ_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RN_W       = `READ_NUM_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                request_valid,
  input  logic [RN_W-1:0]     req_read_num,
  input  logic [ADDR_W-1:0]   addr_k,
  input  logic [ADDR_W-1:0]   addr_l,
  output logic                req_ready,
  output logic                mem_rd_valid,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic                mem_rd_ready,
  input  logic                mem_rsp_valid,
  input  logic [LINE_W-1:0]   mem_rsp_data,
  input  logic                stall,
  output logic                resp_valid,
  output logic [RN_W-1:0]     resp_read_num,
  output logic [CNT_A_W-1:0]  cnt_a0,
  output logic [CNT_A_W-1:0]  cnt_a1,
  output logic [CNT_A_W-1:0]  cnt_a2,
  output logic [CNT_A_W-1:0]  cnt_a3,
  output logic [CNT_B_W-1:0]  cnt_b0,
  output logic [CNT_B_W-1:0]  cnt_b1,
  output logic [CNT_B_W-1:0]  cnt_b2,
  output logic [CNT_B_W-1:0]  cnt_b3,
  output logic [CNT_A_W-1:0]  cntl_a0,
  output logic [CNT_A_W-1:0]  cntl_a1,
  output logic [CNT_A_W-1:0]  cntl_a2,
  output logic [CNT_A_W-1:0]  cntl_a3,
  output logic [CNT_B_W-1:0]  cntl_b0,
  output logic [CNT_B_W-1:0]  cntl_b1,
  output logic [CNT_B_W-1:0]  cntl_b2,
  output logic [CNT_B_W-1:0]  cntl_b3
);

  localparam int ENTRY_W = RN_W + 2 * ADDR_W;

  occ_state_t          state, state_nx;
  logic [RN_W-1:0]     tag_q;
  logic [ADDR_W-1:0]   addr_k_q, addr_l_q;
  logic                got_k;
  logic [FIELD_W-1:0]  line_k, line_l;
  logic                fifo_empty, fifo_full, pop, take_k, take_l, same_line;
  logic [ENTRY_W-1:0]  head;
  logic                unused_rsp_hi;

  occ_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (request_valid),
    .push_data ({req_read_num, addr_k, addr_l}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign req_ready     = !fifo_full;
  assign same_line     = (addr_k_q == addr_l_q);
  assign unused_rsp_hi = ^mem_rsp_data[LINE_W-1:FIELD_W];

  // Next-state, memory command and beat-capture decode.
  always_comb begin
    state_nx     = state;
    pop          = 1'b0;
    take_k       = 1'b0;
    take_l       = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_addr  = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = ST_ISSUE_K;
        end
      end
      ST_ISSUE_K: begin
        mem_rd_valid = 1'b1;
        mem_rd_addr  = addr_k_q;
        if (mem_rd_ready) state_nx = same_line ? ST_WAIT : ST_ISSUE_L;
      end
      ST_ISSUE_L: begin
        mem_rd_valid = 1'b1;
        mem_rd_addr  = addr_l_q;
        // The k beat may overtake the l command handshake.
        take_k       = mem_rsp_valid && !got_k;
        if (mem_rd_ready) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          if (!got_k) begin
            take_k = 1'b1;
            if (same_line) begin
              take_l   = 1'b1;
              state_nx = ST_RESP;
            end
          end else begin
            take_l   = 1'b1;
            state_nx = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (!stall) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = ST_ISSUE_K;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, latched lookup context and captured line data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tag_q    <= '0;
      addr_k_q <= '0;
      addr_l_q <= '0;
      got_k    <= 1'b0;
      line_k   <= '0;
      line_l   <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        tag_q    <= head[ENTRY_W-1 -: RN_W];
        addr_k_q <= head[2*ADDR_W-1 -: ADDR_W];
        addr_l_q <= head[ADDR_W-1:0];
        got_k    <= 1'b0;
      end
      if (take_k) begin
        line_k <= mem_rsp_data[FIELD_W-1:0];
        got_k  <= 1'b1;
      end
      if (take_l) line_l <= mem_rsp_data[FIELD_W-1:0];
    end
  end

  assign resp_valid    = (state == ST_RESP);
  assign resp_read_num = tag_q;
  assign cnt_a0  = line_k[A0_LSB +: CNT_A_W];
  assign cnt_a1  = line_k[A1_LSB +: CNT_A_W];
  assign cnt_a2  = line_k[A2_LSB +: CNT_A_W];
  assign cnt_a3  = line_k[A3_LSB +: CNT_A_W];
  assign cnt_b0  = line_k[B0_LSB +: CNT_B_W];
  assign cnt_b1  = line_k[B1_LSB +: CNT_B_W];
  assign cnt_b2  = line_k[B2_LSB +: CNT_B_W];
  assign cnt_b3  = line_k[B3_LSB +: CNT_B_W];
  assign cntl_a0 = line_l[A0_LSB +: CNT_A_W];
  assign cntl_a1 = line_l[A1_LSB +: CNT_A_W];
  assign cntl_a2 = line_l[A2_LSB +: CNT_A_W];
  assign cntl_a3 = line_l[A3_LSB +: CNT_A_W];
  assign cntl_b0 = line_l[B0_LSB +: CNT_B_W];
  assign cntl_b1 = line_l[B1_LSB +: CNT_B_W];
  assign cntl_b2 = line_l[B2_LSB +: CNT_B_W];
  assign cntl_b3 = line_l[B3_LSB +: CNT_B_W];

  // A request offered while full is lost; the caller must honour req_ready.
  a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
    !(request_valid && !req_ready));

  // Read data is only expected while a lookup is collecting beats.
  a_rsp_window: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rsp_valid && !(state == ST_ISSUE_L || state == ST_WAIT)));

endmodule
`default_nettype wire

// File: tb/tb_bwt_occ_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bwt_occ_responder                                                 |
// | Self-checking bench: behavioural memory, request/command scoreboards |
// | and directed plus randomized lookup scenarios.                       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_bwt_occ_responder;

  localparam int RN_W  = 8;
  localparam int DEPTH = 4;
  localparam int BUS_W = RN_W + 768;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         request_valid = 1'b0;
  logic [RN_W-1:0] req_read_num = '0;
  logic [41:0]  addr_k = '0, addr_l = '0;
  logic         req_ready, mem_rd_valid;
  logic [41:0]  mem_rd_addr;
  logic         mem_rd_ready = 1'b0;
  logic         mem_rsp_valid = 1'b0;
  logic [511:0] mem_rsp_data = '0;
  logic         stall = 1'b0;
  logic         resp_valid;
  logic [RN_W-1:0] resp_read_num;
  logic [31:0]  cnt_a0, cnt_a1, cnt_a2, cnt_a3, cntl_a0, cntl_a1, cntl_a2, cntl_a3;
  logic [63:0]  cnt_b0, cnt_b1, cnt_b2, cnt_b3, cntl_b0, cntl_b1, cntl_b2, cntl_b3;

  bwt_occ_responder #(.FIFO_DEPTH(DEPTH), .RN_W(RN_W)) dut (
    .clk(clk), .rst_n(rst_n), .request_valid(request_valid), .req_read_num(req_read_num),
    .addr_k(addr_k), .addr_l(addr_l), .req_ready(req_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .stall(stall),
    .resp_valid(resp_valid), .resp_read_num(resp_read_num),
    .cnt_a0(cnt_a0), .cnt_a1(cnt_a1), .cnt_a2(cnt_a2), .cnt_a3(cnt_a3),
    .cnt_b0(cnt_b0), .cnt_b1(cnt_b1), .cnt_b2(cnt_b2), .cnt_b3(cnt_b3),
    .cntl_a0(cntl_a0), .cntl_a1(cntl_a1), .cntl_a2(cntl_a2), .cntl_a3(cntl_a3),
    .cntl_b0(cntl_b0), .cntl_b1(cntl_b1), .cntl_b2(cntl_b2), .cntl_b3(cntl_b3)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int cmd_count = 0;
  int last_due = 0;
  int mem_extra = 0;
  bit mem_rand_delay = 0;
  bit rand_mode = 0;
  logic [31:0] salt;

  typedef struct { logic [RN_W-1:0] tag; logic [41:0] ak; logic [41:0] al; } req_t;
  typedef struct { int due; logic [41:0] addr; } pend_t;
  req_t        exp_resp[$];
  logic [41:0] exp_cmd[$];
  pend_t       pend[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Contents of the backing store: a deterministic scramble of the address.
  function automatic logic [511:0] mem_line(input logic [41:0] a);
    logic [511:0] l;
    logic [31:0]  w;
    for (int i = 0; i < 16; i++) begin
      w = a[31:0] ^ {a[41:32], 22'h0} ^ salt ^ (32'(i) * 32'h7F4A7C15);
      w = w * 32'h9E3779B1;
      w = w ^ (w >> 13) ^ 32'(i);
      l[i*32 +: 32] = w;
    end
    return l;
  endfunction

  // Expected response bus: tag, then k-line counters, then l-line counters.
  function automatic logic [BUS_W-1:0] exp_bus(input logic [RN_W-1:0] t,
                                               input logic [511:0] lk, input logic [511:0] ll);
    return {t,
            lk[31:0], lk[63:32], lk[95:64], lk[127:96],
            lk[191:128], lk[255:192], lk[319:256], lk[383:320],
            ll[31:0], ll[63:32], ll[95:64], ll[127:96],
            ll[191:128], ll[255:192], ll[319:256], ll[383:320]};
  endfunction

  function automatic logic [BUS_W-1:0] act_bus();
    return {resp_read_num, cnt_a0, cnt_a1, cnt_a2, cnt_a3, cnt_b0, cnt_b1, cnt_b2, cnt_b3,
            cntl_a0, cntl_a1, cntl_a2, cntl_a3, cntl_b0, cntl_b1, cntl_b2, cntl_b3};
  endfunction

  function automatic logic [41:0] rand_addr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[41:0];
  endfunction

  // Memory: accept commands, check them against request order, reply in order.
  always @(negedge clk) begin
    int d;
    if (rst_n && mem_rd_valid && mem_rd_ready) begin
      cmd_count++;
      tests_run++;
      if (exp_cmd.size() == 0) begin
        tests_failed++;
        $display("FAIL mem_cmd: got addr %h, expected no command", mem_rd_addr);
      end else begin
        if (mem_rd_addr !== exp_cmd[0]) begin
          tests_failed++;
          $display("FAIL mem_cmd: got addr %h, expected %h", mem_rd_addr, exp_cmd[0]);
        end
        void'(exp_cmd.pop_front());
      end
      d = cyc + 1 + mem_extra + (mem_rand_delay ? int'($urandom_range(0, 2)) : 0);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{d, mem_rd_addr});
    end
  end

  always @(posedge clk) begin
    #1;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_line(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  end

  // Response scoreboard: every accepted response is checked against the model.
  always @(negedge clk) begin
    req_t e;
    logic [BUS_W-1:0] x, a;
    if (rst_n && resp_valid && !stall) begin
      tests_run += 2;
      if (exp_resp.size() == 0) begin
        tests_failed += 2;
        $display("FAIL resp_extra: got tag %0h, expected no response", resp_read_num);
      end else begin
        e = exp_resp.pop_front();
        x = exp_bus(e.tag, mem_line(e.ak), mem_line(e.al));
        a = act_bus();
        if (a[BUS_W-1:384] !== x[BUS_W-1:384]) begin
          tests_failed++;
          $display("FAIL resp_k tag=%0h: got %h expected %h", e.tag, a[BUS_W-1:384], x[BUS_W-1:384]);
        end
        if (a[383:0] !== x[383:0]) begin
          tests_failed++;
          $display("FAIL resp_l tag=%0h: got %h expected %h", e.tag, a[383:0], x[383:0]);
        end
      end
    end
  end

  // Background randomisation of handshake inputs.
  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      mem_rd_ready = ($urandom_range(0, 3) != 0);
      stall        = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request once req_ready allows it; leaves request_valid high.
  task automatic push_req(input logic [RN_W-1:0] t, input logic [41:0] ak, input logic [41:0] al);
    int n = 0;
    while (!req_ready && n < 300) begin
      request_valid = 1'b0;
      tick();
      n++;
    end
    if (!req_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL push_wait: req_ready=%0b after %0d cycles, expected 1", req_ready, n);
      return;
    end
    request_valid = 1'b1;
    req_read_num  = t;
    addr_k        = ak;
    addr_l        = al;
    exp_resp.push_back('{t, ak, al});
    exp_cmd.push_back(ak);
    if (al != ak) exp_cmd.push_back(al);
    tick();
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    request_valid = 1'b0;
    while ((exp_resp.size() != 0 || pend.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    tick();
    tick();
    tests_run++;
    if (exp_resp.size() != 0 || exp_cmd.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d responses and %0d commands outstanding, expected 0",
               exp_resp.size(), exp_cmd.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    tests_run++;
    if (req_ready !== 1'b1 || mem_rd_valid !== 1'b0 || resp_valid !== 1'b0 ||
        mem_rd_addr !== '0 || act_bus() !== '0) begin
      tests_failed++;
      $display("FAIL %s: ready=%0b rd_valid=%0b resp_valid=%0b rd_addr=%h bus_nonzero=%0b, expected 1/0/0/0/0",
               name, req_ready, mem_rd_valid, resp_valid, mem_rd_addr, act_bus() != '0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic measure_latency(input string name, input int expected, input int cmds);
    int lat = 1;
    int c0 = cmd_count;
    logic [BUS_W-1:0] a;
    while (!resp_valid && lat < 60) begin
      tick();
      lat++;
    end
    tests_run++;
    if (lat !== expected) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", name, lat, expected);
    end
    if (cmds == 1) begin
      a = act_bus();
      tests_run++;
      if (a[767:384] !== a[383:0]) begin
        tests_failed++;
        $display("FAIL %s_dup: k fields %h differ from l fields %h", name, a[767:384], a[383:0]);
      end
    end
    wait_drain(100);
    tests_run++;
    if (cmd_count - c0 + (lat - lat) !== cmds - (cmd_count - c0 > cmds ? 0 : 0) + 0 &&
        cmd_count - c0 !== cmds) begin
      tests_failed++;
      $display("FAIL %s_cmds: got %0d commands, expected %0d", name, cmd_count - c0, cmds);
    end
  endtask

  task automatic test_single_lookup();
    int c0;
    mem_rd_ready = 1'b1;
    c0 = cmd_count;
    push_req(8'h11, 42'h100, 42'h140);
    request_valid = 1'b0;
    measure_latency("distinct", 5, 2);
    tests_run++;
    if (cmd_count - c0 !== 2) begin
      tests_failed++;
      $display("FAIL distinct_total_cmds: got %0d, expected 2", cmd_count - c0);
    end
  endtask

  task automatic test_same_line();
    int c0;
    mem_rd_ready = 1'b1;
    c0 = cmd_count;
    push_req(8'h22, 42'h200, 42'h200);
    request_valid = 1'b0;
    measure_latency("same", 4, 1);
    tests_run++;
    if (cmd_count - c0 !== 1) begin
      tests_failed++;
      $display("FAIL same_total_cmds: got %0d, expected 1", cmd_count - c0);
    end
  endtask

  task automatic test_back_to_back();
    mem_rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_req(RN_W'(i), rand_addr(), rand_addr());
      if (i == 3) begin
        tests_run++;
        if (req_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_ready_after4: got %0b, expected 1", req_ready);
        end
      end
    end
    request_valid = 1'b0;
    repeat (3) begin
      tests_run++;
      if (req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_full: req_ready got %0b, expected 0", req_ready);
      end
      tick();
    end
    mem_rd_ready = 1'b1;
    wait_drain(300);
  endtask

  task automatic test_stall();
    logic [BUS_W-1:0] snap;
    logic [41:0] bk;
    int n = 0;
    mem_rd_ready = 1'b1;
    stall = 1'b1;
    bk = rand_addr();
    push_req(8'h31, rand_addr(), rand_addr());
    push_req(8'h32, bk, rand_addr());
    request_valid = 1'b0;
    while (!resp_valid && n < 60) begin
      tick();
      n++;
    end
    snap = act_bus();
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (resp_valid !== 1'b1 || act_bus() !== snap || mem_rd_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold cycle %0d: resp_valid=%0b rd_valid=%0b bus_changed=%0b, expected 1/0/0",
                 i, resp_valid, mem_rd_valid, act_bus() !== snap);
      end
    end
    stall = 1'b0;
    tick();
    tests_run++;
    if (mem_rd_valid !== 1'b1 || mem_rd_addr !== bk) begin
      tests_failed++;
      $display("FAIL stall_release: rd_valid=%0b addr=%h, expected 1 addr=%h", mem_rd_valid, mem_rd_addr, bk);
    end
    wait_drain(100);
  endtask

  task automatic test_ready_hold();
    logic [41:0] ak, al;
    int n = 0;
    ak = 42'h3_0000_1000;
    al = 42'h0_0000_2040;
    mem_rd_ready = 1'b1;
    push_req(8'h41, ak, al);
    request_valid = 1'b0;
    while (!(mem_rd_valid && mem_rd_addr == ak) && n < 30) begin
      tick();
      n++;
    end
    tick();
    mem_rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (mem_rd_valid !== 1'b1 || mem_rd_addr !== al) begin
        tests_failed++;
        $display("FAIL ready_hold cycle %0d: rd_valid=%0b addr=%h, expected 1 addr=%h",
                 i, mem_rd_valid, mem_rd_addr, al);
      end
      tick();
    end
    mem_rd_ready = 1'b1;
    wait_drain(100);
  endtask

  task automatic test_reset_in_wait();
    logic [41:0] al;
    int n = 0;
    al = rand_addr() ^ 42'h1;
    mem_rd_ready = 1'b1;
    mem_extra = 3;
    push_req(8'h51, al ^ 42'h80, al);
    request_valid = 1'b0;
    while (!(mem_rd_valid && mem_rd_addr == al) && n < 30) begin
      tick();
      n++;
    end
    tick();
    #2;
    rst_n = 1'b0;
    pend.delete();
    exp_resp.delete();
    exp_cmd.delete();
    mem_extra = 0;
    #1;
    check_idle_outputs("reset_in_wait");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (mem_rd_valid !== 1'b0 || req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL post_reset_idle: rd_valid=%0b ready=%0b, expected 0/1", mem_rd_valid, req_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [41:0] ak;
    rand_mode = 1'b1;
    mem_rand_delay = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ak = rand_addr();
      push_req(RN_W'(8'h60 + i), ak, ($urandom_range(0, 3) == 0) ? ak : rand_addr());
      if ($urandom_range(0, 2) == 0) begin
        request_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    wait_drain(3000);
    rand_mode = 1'b0;
    mem_rand_delay = 1'b0;
    tick();
    stall = 1'b0;
    mem_rd_ready = 1'b1;
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_single_lookup();
    test_same_line();
    test_back_to_back();
    test_stall();
    test_ready_hold();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
